// File: rtl/waveform_to_pipe.sv
// waveform_to_pipe: captures one 32-bit sample per rising edge of the slow
// simulation clock, buffers it in a FIFO and streams it to an okBTPipeOut as
// two 16-bit words (low half first) in the ti_clk domain.
// Optional feature macro: WAVEFORM_TO_PIPE_TAG_EN replaces bits [15:8] of the
// high-half word with an 8-bit sequence number of written samples.
module waveform_to_pipe #(
  parameter int DEPTH_LOG2  = 10,
  parameter int BLOCK_WORDS = 256
) (
  input  logic                  ti_clk,
  input  logic                  reset_n,
  input  logic                  sample_clk,
  input  logic [31:0]           sample_data,
  input  logic                  enable,
  input  logic                  ep_read,
  input  logic                  ep_blockstrobe,
  output logic [15:0]           ep_datain,
  output logic                  ep_ready,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic [15:0]           overflow_cnt,
  output logic [15:0]           underrun_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2+1:0] BLOCK_LVL  = (DEPTH_LOG2+2)'(BLOCK_WORDS);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = (DEPTH_LOG2)'(1);
  localparam logic [DEPTH_LOG2:0]   FILL_ONE   = (DEPTH_LOG2+1)'(1);

  logic [1:0]            r_sclkSync;
  logic                  r_sclkPrev;
  logic [31:0]           r_mem [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] r_wrPtr;
  logic [DEPTH_LOG2-1:0] r_rdPtr;
  logic [DEPTH_LOG2:0]   r_fill;
  logic                  r_phase;
  logic [15:0]           r_dout;
  logic                  r_ready;
  logic [15:0]           r_ovfCnt;
  logic [15:0]           r_undCnt;

  logic                  w_tick;
  logic                  w_full;
  logic                  w_notEmpty;
  logic                  w_write;
  logic                  w_drop;
  logic                  w_readData;
  logic                  w_pop;
  logic                  w_underrun;
  logic [31:0]           w_wrWord;
  logic [31:0]           w_headWord;
  logic [DEPTH_LOG2+1:0] w_availWords;
  logic                  w_unused;

  assign w_tick       = r_sclkSync[1] & ~r_sclkPrev;
  assign w_full       = (r_fill == FULL_LEVEL);
  assign w_notEmpty   = (r_fill != '0);
  assign w_write      = w_tick & enable & ~w_full;
  assign w_drop       = w_tick & enable & w_full;
  assign w_readData   = ep_read & w_notEmpty;
  assign w_pop        = w_readData & r_phase;
  assign w_underrun   = ep_read & ~w_notEmpty;
  assign w_headWord   = r_mem[r_rdPtr];
  assign w_availWords = {1'b0, r_fill, 1'b0} - {{(DEPTH_LOG2+1){1'b0}}, r_phase};

`ifdef WAVEFORM_TO_PIPE_TAG_EN
  logic [7:0] r_seq;

  // Sequence number advances only for samples that actually enter the FIFO
  always_ff @(posedge ti_clk) begin
    if (!reset_n)     r_seq <= 8'd0;
    else if (w_write) r_seq <= r_seq + 8'd1;
  end

  assign w_wrWord = {r_seq, sample_data[23:16], sample_data[15:0]};
  assign w_unused = ^{ep_blockstrobe, sample_data[31:24]};
`else
  assign w_wrWord = sample_data;
  assign w_unused = ep_blockstrobe;
`endif

  // Two-flop synchronizer plus a delayed copy for rising-edge detection of sample_clk
  always_ff @(posedge ti_clk) begin
    if (!reset_n) begin
      r_sclkSync <= 2'b00;
      r_sclkPrev <= 1'b0;
    end else begin
      r_sclkSync <= {r_sclkSync[0], sample_clk};
      r_sclkPrev <= r_sclkSync[1];
    end
  end

  // Sample storage; contents need no reset since fill/pointers define validity
  always_ff @(posedge ti_clk) begin
    if (w_write) r_mem[r_wrPtr] <= w_wrWord;
  end

  // Pointers and occupancy; a write and a pop in the same cycle cancel in the fill count
  always_ff @(posedge ti_clk) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_fill  <= '0;
    end else begin
      if (w_write) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_pop)   r_rdPtr <= r_rdPtr + PTR_ONE;
      if (w_write && !w_pop)      r_fill <= r_fill + FILL_ONE;
      else if (!w_write && w_pop) r_fill <= r_fill - FILL_ONE;
    end
  end

  // Registered pipe output: low half then high half, zeros when read while empty
  always_ff @(posedge ti_clk) begin
    if (!reset_n) begin
      r_dout  <= 16'h0000;
      r_phase <= 1'b0;
    end else if (w_readData) begin
      r_dout  <= r_phase ? w_headWord[31:16] : w_headWord[15:0];
      r_phase <= ~r_phase;
    end else if (w_underrun) begin
      r_dout  <= 16'h0000;
    end
  end

  // Block-ready flag lags the fill/phase state by one cycle
  always_ff @(posedge ti_clk) begin
    if (!reset_n) r_ready <= 1'b0;
    else          r_ready <= (w_availWords >= BLOCK_LVL);
  end

  // Saturating drop and underrun counters
  always_ff @(posedge ti_clk) begin
    if (!reset_n) begin
      r_ovfCnt <= 16'h0000;
      r_undCnt <= 16'h0000;
    end else begin
      if (w_drop && r_ovfCnt != 16'hFFFF)     r_ovfCnt <= r_ovfCnt + 16'd1;
      if (w_underrun && r_undCnt != 16'hFFFF) r_undCnt <= r_undCnt + 16'd1;
    end
  end

  assign ep_datain    = r_dout;
  assign ep_ready     = r_ready;
  assign fill_level   = r_fill;
  assign overflow_cnt = r_ovfCnt;
  assign underrun_cnt = r_undCnt;

endmodule

// File: tb/tb_waveform_to_pipe.sv
// Self-checking bench for waveform_to_pipe: random samples checked against a
// queue-based reference model of the sample FIFO and word streaming.
module tb_waveform_to_pipe;

  localparam int DEPTH_LOG2  = 10;
  localparam int BLOCK_WORDS = 256;
  localparam int DEPTH       = 1 << DEPTH_LOG2;

  logic                ti_clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                sample_clk = 1'b0;
  logic [31:0]         sample_data = 32'd0;
  logic                enable = 1'b0;
  logic                ep_read = 1'b0;
  logic                ep_blockstrobe = 1'b0;
  logic [15:0]         ep_datain;
  logic                ep_ready;
  logic [DEPTH_LOG2:0] fill_level;
  logic [15:0]         overflow_cnt;
  logic [15:0]         underrun_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] mq[$];
  int          mPhase = 0;
  int          mOvf = 0;
  int          mUnd = 0;
  int          mSeq = 0;

  waveform_to_pipe #(.DEPTH_LOG2(DEPTH_LOG2), .BLOCK_WORDS(BLOCK_WORDS)) dut (
    .ti_clk(ti_clk), .reset_n(reset_n), .sample_clk(sample_clk),
    .sample_data(sample_data), .enable(enable), .ep_read(ep_read),
    .ep_blockstrobe(ep_blockstrobe), .ep_datain(ep_datain), .ep_ready(ep_ready),
    .fill_level(fill_level), .overflow_cnt(overflow_cnt), .underrun_cnt(underrun_cnt)
  );

  always #5 ti_clk = ~ti_clk;

  function automatic bit model_ready();
    return (mq.size() * 2 - mPhase) >= BLOCK_WORDS;
  endfunction

  task automatic model_clear();
    mq.delete();
    mPhase = 0; mOvf = 0; mUnd = 0; mSeq = 0;
  endtask

  task automatic model_write(input logic [31:0] d, input bit en);
    logic [31:0] w;
    if (!en) return;
    if (mq.size() < DEPTH) begin
`ifdef WAVEFORM_TO_PIPE_TAG_EN
      w = {mSeq[7:0], d[23:16], d[15:0]};
      mSeq = (mSeq + 1) % 256;
`else
      w = d;
`endif
      mq.push_back(w);
    end else if (mOvf < 65535) mOvf++;
  endtask

  task automatic model_read(output logic [15:0] w);
    if (mq.size() == 0) begin
      w = 16'h0000;
      if (mUnd < 65535) mUnd++;
    end else if (mPhase == 0) begin
      w = mq[0][15:0];
      mPhase = 1;
    end else begin
      w = mq[0][31:16];
      void'(mq.pop_front());
      mPhase = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge ti_clk);
    reset_n = 1'b0; ep_read = 1'b0; sample_clk = 1'b0; enable = 1'b0;
    repeat (2) @(negedge ti_clk);
    reset_n = 1'b1;
    model_clear();
  endtask

  // One sample_clk period: 2 ti_clk cycles high, 2 low; write lands on the 3rd edge
  task automatic write_sample(input logic [31:0] d, input bit en);
    enable = en; sample_data = d; sample_clk = 1'b1;
    repeat (2) @(negedge ti_clk);
    sample_clk = 1'b0;
    repeat (2) @(negedge ti_clk);
    model_write(d, en);
  endtask

  task automatic read_word(output logic [15:0] got, output logic [15:0] exp);
    ep_read = 1'b1;
    @(negedge ti_clk);
    ep_read = 1'b0;
    got = ep_datain;
    model_read(exp);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge ti_clk);
    checks++;
    if (ep_datain !== 16'h0 || ep_ready !== 1'b0 || fill_level !== '0 ||
        overflow_cnt !== 16'h0 || underrun_cnt !== 16'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got d=%h r=%b f=%0d o=%0d u=%0d required all zero",
               ep_datain, ep_ready, fill_level, overflow_cnt, underrun_cnt);
    end
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic test_basic();
    logic [15:0] got, exp;
    logic [15:0] golden [8];
    golden = '{16'h0002, 16'h0001, 16'h0003, 16'h0002, 16'h0004, 16'h0003, 16'h0005, 16'h0004};
    do_reset();
    for (int i = 0; i < 4; i++) write_sample(32'h00010002 + 32'h00010001 * i, 1'b1);
    checks++;
    if (fill_level !== 11'd4) begin
      failures++;
      $display("[TB] FAIL basic_fill: got %0d required 4", fill_level);
    end
    for (int i = 0; i < 8; i++) begin
      read_word(got, exp);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL basic_word%0d: got %h required %h", i, got, exp);
      end
`ifndef WAVEFORM_TO_PIPE_TAG_EN
      checks++;
      if (got !== golden[i]) begin
        failures++;
        $display("[TB] FAIL basic_golden%0d: got %h required %h", i, got, golden[i]);
      end
`endif
    end
  endtask

  task automatic test_block_ready();
    logic [15:0] got, exp;
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < BLOCK_WORDS/2 - 1; i++) write_sample($urandom, 1'b1);
    checks++;
    if (fill_level !== 11'(BLOCK_WORDS/2 - 1) || ep_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL block_below: got f=%0d r=%b required f=%0d r=0",
               fill_level, ep_ready, BLOCK_WORDS/2 - 1);
    end
    d = $urandom;
    enable = 1'b1; sample_data = d; sample_clk = 1'b1;
    repeat (2) @(negedge ti_clk);
    sample_clk = 1'b0;
    @(negedge ti_clk);
    model_write(d, 1'b1);
    checks++;
    if (fill_level !== 11'(BLOCK_WORDS/2) || ep_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL block_lag: got f=%0d r=%b required f=%0d r=0",
               fill_level, ep_ready, BLOCK_WORDS/2);
    end
    @(negedge ti_clk);
    checks++;
    if (ep_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL block_ready: got %b required 1", ep_ready);
    end
    read_word(got, exp);
    @(negedge ti_clk);
    checks++;
    if (got !== exp || ep_ready !== model_ready()) begin
      failures++;
      $display("[TB] FAIL block_after_read: got w=%h r=%b required w=%h r=%b",
               got, ep_ready, exp, model_ready());
    end
  endtask

  task automatic test_overflow();
    logic [15:0] got, exp;
    logic [31:0] first;
    do_reset();
    first = $urandom;
    write_sample(first, 1'b1);
    for (int i = 1; i < DEPTH + 3; i++) write_sample($urandom, 1'b1);
    checks++;
    if (fill_level !== 11'(DEPTH) || overflow_cnt !== 16'd3 || ep_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL overflow_state: got f=%0d o=%0d r=%b required f=%0d o=3 r=1",
               fill_level, overflow_cnt, ep_ready, DEPTH);
    end
    read_word(got, exp);
    checks++;
    if (got !== first[15:0]) begin
      failures++;
      $display("[TB] FAIL overflow_first: got %h required %h", got, first[15:0]);
    end
    for (int i = 1; i < 2 * DEPTH; i++) begin
      read_word(got, exp);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL overflow_drain%0d: got %h required %h", i, got, exp);
      end
    end
    checks++;
    if (fill_level !== '0 || underrun_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL overflow_empty: got f=%0d u=%0d required 0 0", fill_level, underrun_cnt);
    end
  endtask

  task automatic test_underrun();
    logic [15:0] got, exp;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      read_word(got, exp);
      checks++;
      if (got !== 16'h0000) begin
        failures++;
        $display("[TB] FAIL underrun_word%0d: got %h required 0000", i, got);
      end
    end
    checks++;
    if (underrun_cnt !== 16'd2) begin
      failures++;
      $display("[TB] FAIL underrun_cnt: got %0d required 2", underrun_cnt);
    end
    write_sample($urandom, 1'b1);
    read_word(got, exp);
    checks++;
    if (got !== exp || underrun_cnt !== 16'd2) begin
      failures++;
      $display("[TB] FAIL underrun_recover: got w=%h u=%0d required w=%h u=2", got, underrun_cnt, exp);
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] got, exp;
    logic [31:0] b;
    do_reset();
    write_sample($urandom, 1'b1);
    read_word(got, exp);
    checks++;
    if (got !== exp || fill_level !== 11'd1) begin
      failures++;
      $display("[TB] FAIL simul_setup: got w=%h f=%0d required w=%h f=1", got, fill_level, exp);
    end
    b = $urandom;
    enable = 1'b1; sample_data = b; sample_clk = 1'b1;
    repeat (2) @(negedge ti_clk);
    sample_clk = 1'b0;
    read_word(got, exp);
    model_write(b, 1'b1);
    checks++;
    if (got !== exp || fill_level !== 11'd1) begin
      failures++;
      $display("[TB] FAIL simul_both: got w=%h f=%0d required w=%h f=1", got, fill_level, exp);
    end
    @(negedge ti_clk);
    for (int i = 0; i < 2; i++) begin
      read_word(got, exp);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL simul_next%0d: got %h required %h", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_midblock();
    logic [15:0] got, exp;
    do_reset();
    for (int i = 0; i < 5; i++) write_sample($urandom, 1'b1);
    for (int i = 0; i < 3; i++) read_word(got, exp);
    reset_n = 1'b0;
    @(negedge ti_clk);
    checks++;
    if (ep_datain !== 16'h0 || ep_ready !== 1'b0 || fill_level !== '0 ||
        overflow_cnt !== 16'h0 || underrun_cnt !== 16'h0) begin
      failures++;
      $display("[TB] FAIL midblock_reset: got d=%h r=%b f=%0d o=%0d u=%0d required all zero",
               ep_datain, ep_ready, fill_level, overflow_cnt, underrun_cnt);
    end
    reset_n = 1'b1;
    model_clear();
    write_sample($urandom, 1'b1);
    read_word(got, exp);
    checks++;
    if (got !== exp || fill_level !== 11'd1) begin
      failures++;
      $display("[TB] FAIL midblock_restart: got w=%h f=%0d required w=%h f=1", got, fill_level, exp);
    end
  endtask

  task automatic test_random();
    logic [15:0] got, exp;
    do_reset();
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(9) < 6) begin
        write_sample($urandom, $urandom_range(9) != 0);
        checks++;
        if (fill_level !== 11'(mq.size()) || ep_ready !== model_ready()) begin
          failures++;
          $display("[TB] FAIL random_write%0d: got f=%0d r=%b required f=%0d r=%b",
                   n, fill_level, ep_ready, mq.size(), model_ready());
        end
      end else begin
        read_word(got, exp);
        checks++;
        if (got !== exp || fill_level !== 11'(mq.size())) begin
          failures++;
          $display("[TB] FAIL random_read%0d: got w=%h f=%0d required w=%h f=%0d",
                   n, got, fill_level, exp, mq.size());
        end
      end
    end
    checks++;
    if (underrun_cnt !== 16'(mUnd) || overflow_cnt !== 16'(mOvf)) begin
      failures++;
      $display("[TB] FAIL random_counters: got u=%0d o=%0d required u=%0d o=%0d",
               underrun_cnt, overflow_cnt, mUnd, mOvf);
    end
  endtask

  task automatic test_tag_stream();
    logic [15:0] got, exp;
    do_reset();
    for (int i = 0; i < 300; i++) write_sample($urandom, 1'b1);
    for (int i = 0; i < 600; i++) begin
      read_word(got, exp);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL stream_word%0d: got %h required %h", i, got, exp);
      end
`ifdef WAVEFORM_TO_PIPE_TAG_EN
      if (i % 2 == 1) begin
        checks++;
        if (got[15:8] !== 8'((i / 2) % 256)) begin
          failures++;
          $display("[TB] FAIL stream_tag%0d: got %0d required %0d", i / 2, got[15:8], (i / 2) % 256);
        end
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_block_ready();
    test_overflow();
    test_underrun();
    test_simultaneous();
    test_reset_midblock();
    test_random();
    test_tag_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
